stimuli_seq_ctrl: RTL and testbench
===================================

// Module: stimuli_seq_ctrl
// PURPOSE
//  Sequencer for the 64x8192 stimuli RAM in the emulation control path.
//  LOAD phase: accepts a host word stream and writes it to consecutive RAM addresses from 0.
//  PLAY phase: reads the stored words back in order and presents them to the DUT driver as a
//  valid/ready stream, one-shot or looped. Drives the RAM write and read ports directly;
//  the RAM read clock (oclk) is tied to clk.
// PARAMETERS
//  DATA_W   64    stimulus word width
//  ADDR_W   13    RAM address width
//  DEPTH    8192  RAM depth in words (<= 2**ADDR_W)
// PORTS
//  clk           in   1         system clock; RAM clk and oclk are tied to it
//  rst_n         in   1         asynchronous reset, active low
//  load_start    in   1         pulse: begin LOAD
//  play_start    in   1         pulse: begin PLAY
//  loop_en       in   1         sampled at play_start: 1 = replay continuously
//  abort         in   1         pulse: stop current LOAD/PLAY, return to IDLE
//  ld_valid      in   1         host word valid
//  ld_data       in   DATA_W    host word
//  ld_last       in   1         marks final word of the load
//  ld_ready      out  1         controller accepts host word
//  ram_wen       out  1         RAM write enable (registered)
//  ram_wraddr    out  ADDR_W    RAM write address (registered)
//  ram_din       out  DATA_W    RAM write data (registered)
//  ram_rdaddr    out  ADDR_W    RAM read address (registered)
//  ram_dout      in   DATA_W    RAM read data; valid 1 clk after ram_rdaddr is presented
//  st_valid      out  1         stimulus word valid to DUT driver
//  st_data       out  DATA_W    stimulus word
//  st_ready      in   1         DUT driver accepts word
//  stored_len    out  ADDR_W+1  words held in RAM (0..DEPTH)
//  pass_cnt      out  16        completed play passes, saturating
//  busy          out  1         state != IDLE
//  done          out  1         1-clk pulse when a one-shot PLAY completes
//  err_ovf       out  1         sticky: LOAD reached DEPTH without ld_last
//  err_empty     out  1         sticky: play_start with stored_len == 0
// BEHAVIOUR
//  Reset: state IDLE. All outputs 0: stored_len, pass_cnt, ram_*, st_valid, ld_ready, flags.
//   Skid buffer empty, in-flight read discarded. RAM contents are not cleared.
//  States: IDLE, LOAD, PLAY, DONE.
//  IDLE:
//   - load_start -> LOAD; wr_ptr=0, stored_len=0.
//   - else play_start with stored_len!=0 -> PLAY; rd_ptr=0, pass_cnt=0, loop latched.
//   - play_start with stored_len==0: set err_empty, stay IDLE.
//   - load_start and play_start together: LOAD wins.
//   - Flags clear only on reset or load_start.
//  LOAD:
//   - ld_ready=1. Beat = ld_valid&ld_ready.
//   - Each beat: next clk ram_wen=1, ram_wraddr=wr_ptr, ram_din=ld_data; wr_ptr++, stored_len++.
//   - Beat with ld_last -> IDLE.
//   - Beat making stored_len==DEPTH without ld_last: set err_ovf, -> IDLE.
//   - ld_ready is 0 in every other state.
//  PLAY:
//   - 2-entry skid FIFO plus 1 in-flight read slot.
//   - Issue read (ram_rdaddr=rd_ptr, rd_ptr++) when rd_ptr<stored_len and
//     occupancy + inflight - pop < 2, where pop = st_valid&st_ready this clk.
//   - Returned word enters the FIFO 1 clk after issue.
//   - st_valid = FIFO non-empty; st_data = FIFO head. Sustains 1 word/clk with st_ready high.
//   - First st_valid 2 clks after entering PLAY.
//   - st_data/st_valid stay stable while st_valid & !st_ready.
//   - End of pass (rd_ptr==stored_len), loop=1: rd_ptr wraps to 0 in the same clk, pass_cnt++,
//     no bubble inserted.
//   - End of pass, loop=0: stop issuing; when FIFO empty and nothing in flight, pass_cnt++,
//     -> DONE.
//  DONE: done=1 for this single clk, -> IDLE.
//  abort, any state: next clk IDLE. FIFO flushed, in-flight read dropped, st_valid=0, no done.
//   - Abort in LOAD: stored_len keeps beats already written.
//  load_start/play_start are ignored outside IDLE.
//  Widths: pointers and stored_len are ADDR_W+1 bits; RAM addresses are the low ADDR_W bits.
// TESTING
//  T1 load 5 words 0xA0..0xA4 (last on 5th) then play_start, st_ready=1 -> st_data A0..A4
//     on 5 consecutive clks, done pulse 1 clk after last pop, stored_len=5, pass_cnt=1.
//  T2 3 stored words, st_ready toggled 1/0 each clk -> every word delivered exactly once,
//     in order, held stable while stalled.
//  T3 loop_en=1, 3 words, st_ready=1 for 9 clks then abort -> A0,A1,A2 x3 back-to-back,
//     pass_cnt=3, no done, busy=0 next clk.
//  T4 DEPTH=16, stream 20 words, no last -> 16 written, err_ovf=1, ld_ready=0 after the 16th.
//  T5 play_start with stored_len=0 -> err_empty=1, busy stays 0, st_valid stays 0.
//  T6 rst_n low mid-LOAD after 3 words -> all outputs 0 asynchronously; load of 2 words
//     then play -> exactly those 2 words out.

Source files
------------

// File: rtl/stimuli_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : stimuli_seq_ctrl
// Brief   : Loads a host word stream into the stimuli RAM, then replays it to
//           the DUT driver as a valid/ready stream (one-shot or looped).
// Revision: 1.0  initial release
// ============================================================================
module stimuli_seq_ctrl #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 13,
  parameter int DEPTH  = 8192
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load_start,
  input  logic              i_play_start,
  input  logic              i_loop_en,
  input  logic              i_abort,
  input  logic              i_ld_valid,
  input  logic [DATA_W-1:0] i_ld_data,
  input  logic              i_ld_last,
  output logic              o_ld_ready,
  output logic              o_ram_wen,
  output logic [ADDR_W-1:0] o_ram_wraddr,
  output logic [DATA_W-1:0] o_ram_din,
  output logic [ADDR_W-1:0] o_ram_rdaddr,
  input  logic [DATA_W-1:0] i_ram_dout,
  output logic              o_st_valid,
  output logic [DATA_W-1:0] o_st_data,
  input  logic              i_st_ready,
  output logic [ADDR_W:0]   o_stored_len,
  output logic [15:0]       o_pass_cnt,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err_ovf,
  output logic              o_err_empty
);

  localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] c_ONE   = (ADDR_W+1)'(1);
  localparam logic [15:0]     c_PASS_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PLAY = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_rd_ptr;
  logic [15:0]       r_pass;
  logic              r_loop;
  logic              r_inflight;
  logic              r_done;
  logic              r_err_ovf;
  logic              r_err_empty;
  logic              r_wen;
  logic [ADDR_W-1:0] r_wraddr;
  logic [DATA_W-1:0] r_din;
  logic [ADDR_W-1:0] r_rdaddr;
  logic [DATA_W-1:0] r_fifo0;
  logic [DATA_W-1:0] r_fifo1;
  logic              r_fwp;
  logic              r_frp;
  logic [1:0]        r_fcnt;

  logic              w_in_play;
  logic              w_pop;
  logic              w_wrap;
  logic [ADDR_W:0]   w_rd_idx;
  logic [2:0]        w_occ_sum;
  logic              w_issue;
  logic              w_play_end;
  logic [ADDR_W:0]   w_len_inc;

  assign w_in_play = (r_state == S_PLAY);
  assign w_pop     = (r_fcnt != 2'd0) & i_st_ready;
  // Looping restarts from address 0 in the same cycle the pass ends.
  assign w_wrap    = w_in_play & r_loop & (r_rd_ptr == r_len);
  assign w_rd_idx  = w_wrap ? '0 : r_rd_ptr;
  // Occupancy after this edge: the in-flight word lands, a popped word leaves.
  assign w_occ_sum = {1'b0, r_fcnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue   = w_in_play & (w_rd_idx < r_len) & (w_occ_sum < 3'd2);
  assign w_play_end = w_in_play & ~r_loop & (r_rd_ptr == r_len) & (w_occ_sum == 3'd0);
  assign w_len_inc = r_len + c_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_rd_ptr    <= '0;
      r_pass      <= '0;
      r_loop      <= 1'b0;
      r_inflight  <= 1'b0;
      r_done      <= 1'b0;
      r_err_ovf   <= 1'b0;
      r_err_empty <= 1'b0;
      r_wen       <= 1'b0;
      r_wraddr    <= '0;
      r_din       <= '0;
      r_rdaddr    <= '0;
      r_fifo0     <= '0;
      r_fifo1     <= '0;
      r_fwp       <= 1'b0;
      r_frp       <= 1'b0;
      r_fcnt      <= 2'd0;
    end else begin
      r_wen  <= 1'b0;
      r_done <= 1'b0;
      if (i_abort) begin
        r_state    <= S_IDLE;
        r_fcnt     <= 2'd0;
        r_fwp      <= 1'b0;
        r_frp      <= 1'b0;
        r_inflight <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_load_start) begin
              r_state     <= S_LOAD;
              r_len       <= '0;
              r_err_ovf   <= 1'b0;
              r_err_empty <= 1'b0;
            end else if (i_play_start) begin
              if (r_len != '0) begin
                r_state    <= S_PLAY;
                r_rd_ptr   <= '0;
                r_pass     <= '0;
                r_loop     <= i_loop_en;
                r_fwp      <= 1'b0;
                r_frp      <= 1'b0;
                r_fcnt     <= 2'd0;
                r_inflight <= 1'b0;
              end else begin
                r_err_empty <= 1'b1;
              end
            end
          end

          S_LOAD: begin
            if (i_ld_valid) begin
              r_wen    <= 1'b1;
              r_wraddr <= r_len[ADDR_W-1:0];
              r_din    <= i_ld_data;
              r_len    <= w_len_inc;
              if (i_ld_last) begin
                r_state <= S_IDLE;
              end else if (w_len_inc == c_DEPTH) begin
                r_err_ovf <= 1'b1;
                r_state   <= S_IDLE;
              end
            end
          end

          S_PLAY: begin
            if (r_inflight) begin
              if (r_fwp) r_fifo1 <= i_ram_dout;
              else       r_fifo0 <= i_ram_dout;
              r_fwp <= ~r_fwp;
            end
            if (w_pop) r_frp <= ~r_frp;
            r_fcnt     <= w_occ_sum[1:0];
            r_inflight <= w_issue;
            if (w_issue) begin
              r_rdaddr <= w_rd_idx[ADDR_W-1:0];
              r_rd_ptr <= w_rd_idx + c_ONE;
            end else if (w_wrap) begin
              r_rd_ptr <= '0;
            end
            if ((w_wrap || w_play_end) && (r_pass != c_PASS_MAX)) begin
              r_pass <= r_pass + 16'd1;
            end
            if (w_play_end) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end

          S_DONE: begin
            r_state <= S_IDLE;
          end

          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign o_ld_ready   = (r_state == S_LOAD);
  assign o_busy       = (r_state != S_IDLE);
  assign o_ram_wen    = r_wen;
  assign o_ram_wraddr = r_wraddr;
  assign o_ram_din    = r_din;
  assign o_ram_rdaddr = r_rdaddr;
  assign o_st_valid   = (r_fcnt != 2'd0);
  assign o_st_data    = r_frp ? r_fifo1 : r_fifo0;
  assign o_stored_len = r_len;
  assign o_pass_cnt   = r_pass;
  assign o_done       = r_done;
  assign o_err_ovf    = r_err_ovf;
  assign o_err_empty  = r_err_empty;

endmodule
`default_nettype wire

// File: tb/tb_stimuli_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_stimuli_seq_ctrl
// Brief   : Directed self-checking bench for stimuli_seq_ctrl with a RAM model.
// Revision: 1.0  initial release
// ============================================================================
module tb_stimuli_seq_ctrl;

  localparam int DW  = 64;
  localparam int AW  = 13;
  localparam int DEP = 16;

  logic          clk;
  logic          rst_n;
  logic          load_start, play_start, loop_en, abort;
  logic          ld_valid, ld_last, ld_ready;
  logic [DW-1:0] ld_data;
  logic          ram_wen;
  logic [AW-1:0] ram_wraddr, ram_rdaddr;
  logic [DW-1:0] ram_din, ram_dout;
  logic          st_valid, st_ready;
  logic [DW-1:0] st_data;
  logic [AW:0]   stored_len;
  logic [15:0]   pass_cnt;
  logic          busy, done, err_ovf, err_empty;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] got_q [$];
  int            n_total = 0;
  int            n_bad   = 0;
  int            stall_err;
  bit            saw_done;

  stimuli_seq_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load_start (load_start),
    .i_play_start (play_start),
    .i_loop_en    (loop_en),
    .i_abort      (abort),
    .i_ld_valid   (ld_valid),
    .i_ld_data    (ld_data),
    .i_ld_last    (ld_last),
    .o_ld_ready   (ld_ready),
    .o_ram_wen    (ram_wen),
    .o_ram_wraddr (ram_wraddr),
    .o_ram_din    (ram_din),
    .o_ram_rdaddr (ram_rdaddr),
    .i_ram_dout   (ram_dout),
    .o_st_valid   (st_valid),
    .o_st_data    (st_data),
    .i_st_ready   (st_ready),
    .o_stored_len (stored_len),
    .o_pass_cnt   (pass_cnt),
    .o_busy       (busy),
    .o_done       (done),
    .o_err_ovf    (err_ovf),
    .o_err_empty  (err_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM whose address register is the controller's registered ram_rdaddr.
  always @(posedge clk) if (ram_wen) mem[ram_wraddr] <= ram_din;
  assign ram_dout = mem[ram_rdaddr];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_words(input int n, input logic [DW-1:0] base, input bit with_last);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("ld_ready_in_load", ld_ready, 1);
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_data  = base + DW'(i);
      ld_last  = with_last && (i == n - 1);
      tick();
      check("ram_wen", ram_wen, 1);
      check("ram_wraddr", ram_wraddr, i);
      check("ram_din", ram_din, base + DW'(i));
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic play_collect(input bit toggle, input int budget);
    logic [DW-1:0] prev_data;
    bit            prev_stall;
    got_q.delete();
    stall_err  = 0;
    saw_done   = 1'b0;
    prev_stall = 1'b0;
    prev_data  = '0;
    loop_en    = 1'b0;
    st_ready   = 1'b1;
    play_start = 1'b1;
    tick();
    play_start = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (prev_stall && !(st_valid && st_data == prev_data)) stall_err++;
      st_ready = toggle ? (c % 2 == 0) : 1'b1;
      if (st_valid && st_ready) got_q.push_back(st_data);
      prev_stall = st_valid && !st_ready;
      prev_data  = st_data;
      if (done) begin
        saw_done = 1'b1;
        break;
      end
      tick();
    end
    st_ready = 1'b0;
  endtask

  initial begin
    int first_c, last_c;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    rst_n = 1'b0; load_start = 0; play_start = 0; loop_en = 0; abort = 0;
    ld_valid = 0; ld_last = 0; ld_data = '0; st_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_ld_ready", ld_ready, 0);
    check("rst_stored_len", stored_len, 0);
    check("rst_pass_cnt", pass_cnt, 0);
    check("rst_st_valid", st_valid, 0);
    check("rst_ram_wen", ram_wen, 0);
    check("rst_flags", {err_ovf, err_empty, done}, 0);
    rst_n = 1'b1;
    tick();

    // T1: one-shot play of 5 words with st_ready held high
    load_words(5, 64'hA0, 1'b1);
    check("t1_stored_len", stored_len, 5);
    check("t1_idle_after_load", busy, 0);
    st_ready = 1'b1; loop_en = 1'b0; play_start = 1'b1;
    tick();
    play_start = 1'b0;
    check("t1_busy", busy, 1);
    check("t1_valid_c0", st_valid, 0);
    tick();
    check("t1_valid_c1", st_valid, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t1_valid", st_valid, 1);
      check("t1_data", st_data, 64'hA0 + 64'(i));
      check("t1_no_early_done", done, 0);
    end
    tick();
    check("t1_done", done, 1);
    check("t1_valid_end", st_valid, 0);
    check("t1_pass_cnt", pass_cnt, 1);
    tick();
    check("t1_done_pulse", done, 0);
    check("t1_busy_end", busy, 0);
    st_ready = 1'b0;

    // T2: st_ready toggling, words held while stalled
    load_words(3, 64'hB0, 1'b1);
    play_collect(1'b1, 40);
    check("t2_done_seen", saw_done, 1);
    check("t2_count", got_q.size(), 3);
    for (int i = 0; i < got_q.size(); i++) check("t2_order", got_q[i], 64'hB0 + 64'(i));
    check("t2_stall_hold", stall_err, 0);
    check("t2_pass_cnt", pass_cnt, 1);
    tick();

    // T3: looped play, 9 back-to-back words, then abort
    load_words(3, 64'hC0, 1'b1);
    loop_en = 1'b1; st_ready = 1'b1; play_start = 1'b1;
    tick();
    play_start = 1'b0; loop_en = 1'b0;
    got_q.delete(); saw_done = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 40; c++) begin
      if (done) saw_done = 1'b1;
      if (st_valid) begin
        got_q.push_back(st_data);
        if (first_c < 0) first_c = c;
        last_c = c;
      end
      if (got_q.size() == 9) break;
      tick();
    end
    tick();
    check("t3_pass_cnt_run", pass_cnt, 3);
    st_ready = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t3_count", got_q.size(), 9);
    for (int i = 0; i < got_q.size(); i++) check("t3_order", got_q[i], 64'hC0 + 64'(i % 3));
    check("t3_back_to_back", last_c - first_c, 8);
    check("t3_busy_after_abort", busy, 0);
    check("t3_st_valid_after_abort", st_valid, 0);
    check("t3_pass_cnt", pass_cnt, 3);
    check("t3_no_done", {saw_done, done}, 0);

    // T4: overflow without ld_last
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    first_c = 0;
    for (int i = 0; i < 20; i++) begin
      ld_valid = 1'b1;
      ld_data  = 64'hD00 + 64'(i);
      if (ld_ready) first_c++;
      tick();
    end
    ld_valid = 1'b0;
    check("t4_beats", first_c, DEP);
    check("t4_stored_len", stored_len, DEP);
    check("t4_err_ovf", err_ovf, 1);
    check("t4_ld_ready", ld_ready, 0);
    check("t4_last_word", mem[DEP-1], 64'hD00 + 64'(DEP - 1));

    // T5: play with nothing stored
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("t5_err_ovf_cleared", err_ovf, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_stored_len", stored_len, 0);
    play_start = 1'b1;
    tick();
    play_start = 1'b0;
    check("t5_err_empty", err_empty, 1);
    check("t5_busy", busy, 0);
    tick();
    check("t5_busy_stays", busy, 0);
    check("t5_st_valid", st_valid, 0);

    // T6: asynchronous reset mid-load, then a fresh 2-word load and play
    load_words(3, 64'hF0, 1'b0);
    check("t6_busy_mid_load", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_stored_len", stored_len, 0);
    check("t6_rst_ld_ready", ld_ready, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_ram_wen", ram_wen, 0);
    check("t6_rst_flags", {err_ovf, err_empty}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    load_words(2, 64'hE0, 1'b1);
    check("t6_stored_len", stored_len, 2);
    play_collect(1'b0, 30);
    check("t6_done_seen", saw_done, 1);
    check("t6_count", got_q.size(), 2);
    for (int i = 0; i < got_q.size(); i++) check("t6_order", got_q[i], 64'hE0 + 64'(i));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
